// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Shares one single-ported, variable-latency memory between  |
// |               the instruction fetch port and the data (load/store) port. |
// |               Data has priority; a starvation counter forces a fetch     |
// |               grant after STARVE_LIMIT data grants taken while fetch     |
// |               was waiting. Produces per-port stall signals.              |
// | Ports       : clk, rst (async, active high)                              |
// |               if_*  : fetch req/ready port, flush, read data, stall      |
// |               d_*   : data req/ready port, we/be/addr/wdata, rdata, stall|
// |               mem_* : memory req/ack port with registered attributes     |
// |               busy_o, grant_owner_o : status (owner 0=fetch, 1=data)     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // fetch port
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_flush_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_ready_o,
  output logic                    if_stall_o,
  // data port
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_ready_o,
  output logic                    d_stall_o,
  // memory port
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i,
  // status
  output logic                    busy_o,
  output logic                    grant_owner_o
);

  localparam int         C_BE_W  = DATA_WIDTH / 8;
  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [C_BE_W-1:0]       mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic                    if_ready_q, if_ready_d;
  logic                    d_ready_q, d_ready_d;
  logic                    grant_owner_q, grant_owner_d;
  logic [3:0]              starve_cnt_q, starve_cnt_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    w_if_cand;

  // A flush in IDLE hides the fetch request for that cycle only.
  assign w_if_cand = if_req_i & ~if_flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_ready_q    <= 1'b0;
      d_ready_q     <= 1'b0;
      grant_owner_q <= 1'b0;
      starve_cnt_q  <= 4'd0;
      flush_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ready_q    <= if_ready_d;
      d_ready_q     <= d_ready_d;
      grant_owner_q <= grant_owner_d;
      starve_cnt_q  <= starve_cnt_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_be_d      = mem_be_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ready_d    = 1'b0;
    d_ready_d     = 1'b0;
    grant_owner_d = grant_owner_q;
    starve_cnt_d  = starve_cnt_q;
    flush_pend_d  = flush_pend_q;

    case (state_q)
      ST_IDLE: begin
        // Data wins unless fetch is both eligible and has been starved.
        if (d_req_i && !(w_if_cand && (starve_cnt_q == C_LIMIT))) begin
          state_d       = ST_DATA;
          mem_req_d     = 1'b1;
          mem_we_d      = d_we_i;
          mem_be_d      = d_be_i;
          mem_addr_d    = d_addr_i;
          mem_wdata_d   = d_wdata_i;
          grant_owner_d = 1'b1;
          if (if_req_i && (starve_cnt_q != C_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (w_if_cand) begin
          state_d       = ST_FETCH;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b0;
          mem_be_d      = '1;
          mem_addr_d    = if_addr_i;
          mem_wdata_d   = '0;
          grant_owner_d = 1'b0;
          starve_cnt_d  = 4'd0;
        end
      end

      ST_FETCH: begin
        if (if_flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack_i) begin
          // The memory access cannot be aborted; a flushed fetch simply
          // completes silently without touching if_rdata.
          state_d      = ST_DONE;
          mem_req_d    = 1'b0;
          flush_pend_d = 1'b0;
          if (!(flush_pend_q || if_flush_i)) begin
            if_rdata_d = mem_rdata_i;
            if_ready_d = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (mem_ack_i) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign if_rdata_o    = if_rdata_q;
  assign if_ready_o    = if_ready_q;
  assign if_stall_o    = if_req_i & ~if_ready_q;
  assign d_rdata_o     = d_rdata_q;
  assign d_ready_o     = d_ready_q;
  assign d_stall_o     = d_req_i & ~d_ready_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign grant_owner_o = grant_owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_port_arbiter                                        |
// | Description : Directed self-checking bench for mem_port_arbiter with a   |
// |               configurable wait-state memory responder.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready, if_stall;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready, d_stall;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy, grant_owner;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic [31:0] mem_rdata_val = '0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata), .if_ready_o(if_ready), .if_stall_o(if_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ready_o(d_ready),
    .d_stall_o(d_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .busy_o(busy), .grant_owner_o(grant_owner)
  );

  always #5 clk = ~clk;

  // Memory model: acks after wait_n full cycles of mem_req.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt == wait_n) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_rdata_val;
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if ({mem_req, busy, if_ready, d_ready, grant_owner} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, busy, if_ready, d_ready, grant_owner}); end
    n_cmp++; if ({if_rdata, d_rdata, mem_addr} !== 96'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {if_rdata, d_rdata, mem_addr}); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_fetch();
    wait_n = 0; mem_rdata_val = 32'hE3A01005;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_cmp++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", if_stall); end
    tick(); // cycle 1
    n_cmp++; if ({mem_req, mem_we, mem_be, grant_owner} !== {1'b1, 1'b0, 4'hF, 1'b0}) begin n_err++; $display("FAIL fetch_mem_attr: got %b want 10_1111_0", {mem_req, mem_we, mem_be, grant_owner}); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr: got %h want 00000100", mem_addr); end
    n_cmp++; if ({if_stall, if_ready} !== 2'b10) begin n_err++; $display("FAIL fetch_stall_c1: got %b want 10", {if_stall, if_ready}); end
    tick(); // cycle 2
    n_cmp++; if ({if_ready, if_stall, mem_req} !== 3'b100) begin n_err++; $display("FAIL fetch_ready_c2: got %b want 100", {if_ready, if_stall, mem_req}); end
    n_cmp++; if (if_rdata !== 32'hE3A01005) begin n_err++; $display("FAIL fetch_rdata: got %h want e3a01005", if_rdata); end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({if_ready, busy} !== 2'b00) begin n_err++; $display("FAIL fetch_after: got %b want 00", {if_ready, busy}); end
  endtask

  task automatic test_data_read();
    wait_n = 2; mem_rdata_val = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_cmp++; if ({mem_req, d_ready, d_stall} !== 3'b101) begin n_err++; $display("FAIL dread_wait_c%0d: got %b want 101", c, {mem_req, d_ready, d_stall}); end
    end
    tick(); // cycle 4
    n_cmp++; if ({d_ready, d_stall} !== 2'b10) begin n_err++; $display("FAIL dread_ready_c4: got %b want 10", {d_ready, d_stall}); end
    n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL dread_rdata: got %h want deadbeef", d_rdata); end
    d_req = 1'b0;
    tick();
    n_cmp++; if ({d_ready, d_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_err++; $display("FAIL dread_hold: got %b/%h want 0/deadbeef", d_ready, d_rdata); end
    wait_n = 0;
  endtask

  task automatic test_back_to_back();
    wait_n = 0; mem_rdata_val = 32'h0BAD0BAD;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h40; d_wdata = 32'h1234ABCD;
    tick(); // cycle 1
    n_cmp++; if ({grant_owner, mem_we, mem_be} !== {1'b1, 1'b1, 4'h3}) begin n_err++; $display("FAIL b2b_data_grant: got %b want 1_1_0011", {grant_owner, mem_we, mem_be}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {32'h40, 32'h1234ABCD}) begin n_err++; $display("FAIL b2b_data_attr: got %h want 000000401234abcd", {mem_addr, mem_wdata}); end
    n_cmp++; if (dut.starve_cnt_q !== 4'd1) begin n_err++; $display("FAIL b2b_starve_inc: got %0d want 1", dut.starve_cnt_q); end
    tick(); // cycle 2
    n_cmp++; if ({d_ready, if_stall} !== 2'b11) begin n_err++; $display("FAIL b2b_dready: got %b want 11", {d_ready, if_stall}); end
    n_cmp++; if (d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_write_keeps_rdata: got %h want deadbeef", d_rdata); end
    d_req = 1'b0;
    tick(); // cycle 3: IDLE
    tick(); // cycle 4: fetch granted
    n_cmp++; if ({mem_req, grant_owner, mem_we, mem_be} !== {1'b1, 1'b0, 1'b0, 4'hF}) begin n_err++; $display("FAIL b2b_fetch_grant: got %b want 1_0_0_1111", {mem_req, grant_owner, mem_we, mem_be}); end
    n_cmp++; if (dut.starve_cnt_q !== 4'd0) begin n_err++; $display("FAIL b2b_starve_clr: got %0d want 0", dut.starve_cnt_q); end
    tick(); // cycle 5
    n_cmp++; if ({if_ready, if_rdata} !== {1'b1, 32'h0BAD0BAD}) begin n_err++; $display("FAIL b2b_fetch_done: got %b/%h want 1/0bad0bad", if_ready, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_own [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   exp_cnt [6] = '{1, 2, 3, 4, 0, 0};
    logic got_own [6];
    int   got_cnt [6];
    int   g = 0;
    bit   done = 1'b0;
    logic prev_req = 1'b0;
    for (int i = 0; i < 6; i++) begin got_own[i] = 1'bx; got_cnt[i] = -1; end
    wait_n = 0; mem_rdata_val = 32'h00000400;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h90;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (mem_req && !prev_req && g < 6) begin
        got_own[g] = grant_owner;
        got_cnt[g] = int'(dut.starve_cnt_q);
        g++;
      end
      prev_req = mem_req;
      if (if_ready) if_req = 1'b0;
      if (d_ready && g >= 6) begin d_req = 1'b0; done = 1'b1; end
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL starve_timeout: got %0d grants want 6 within budget", g); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (got_own[i] !== exp_own[i] || got_cnt[i] != exp_cnt[i]) begin n_err++; $display("FAIL starve_grant%0d: got owner %b cnt %0d want owner %b cnt %0d", i, got_own[i], got_cnt[i], exp_own[i], exp_cnt[i]); end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_flush();
    bit saw_ready = 1'b0;
    wait_n = 3; mem_rdata_val = 32'h66666666;
    if_req = 1'b1; if_addr = 32'h500;
    tick(); // cycle 1
    n_cmp++; if ({mem_req, grant_owner} !== 2'b10) begin n_err++; $display("FAIL flush_granted: got %b want 10", {mem_req, grant_owner}); end
    if_flush = 1'b1; if_req = 1'b0;
    tick(); // cycle 2
    if_flush = 1'b0;
    n_cmp++; if ({mem_req, busy} !== 2'b11) begin n_err++; $display("FAIL flush_inflight: got %b want 11", {mem_req, busy}); end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (if_ready) saw_ready = 1'b1;
    end
    n_cmp++; if (saw_ready !== 1'b0) begin n_err++; $display("FAIL flush_no_ready: got %b want 0", saw_ready); end
    n_cmp++; if ({if_rdata, busy} !== {32'h00000400, 1'b0}) begin n_err++; $display("FAIL flush_rdata_kept: got %h/%b want 00000400/0", if_rdata, busy); end
    wait_n = 0; mem_rdata_val = 32'h00200200;
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL flush_refetch_req: got %b/%h want 1/00000200", mem_req, mem_addr); end
    tick();
    n_cmp++; if ({if_ready, if_rdata} !== {1'b1, 32'h00200200}) begin n_err++; $display("FAIL flush_refetch_done: got %b/%h want 1/00200200", if_ready, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_midtx();
    wait_n = 5; mem_rdata_val = 32'h55555555;
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'hA0;
    tick(); // cycle 1: data granted, fetch waiting
    n_cmp++; if ({grant_owner, dut.starve_cnt_q} !== {1'b1, 4'd1}) begin n_err++; $display("FAIL rstmid_pre: got %b/%0d want 1/1", grant_owner, dut.starve_cnt_q); end
    tick(); // cycle 2: still in DATA
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    #1;
    n_cmp++; if ({mem_req, busy, grant_owner, mem_we, mem_be, dut.starve_cnt_q} !== 11'b0) begin n_err++; $display("FAIL rstmid_ctrl: got %b want 0", {mem_req, busy, grant_owner, mem_we, mem_be, dut.starve_cnt_q}); end
    n_cmp++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    tick();
    rst = 1'b0; wait_n = 0; mem_rdata_val = 32'h77777777;
    if_req = 1'b1; if_addr = 32'h700;
    tick(); // cycle 1
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin n_err++; $display("FAIL rstmid_fetch_req: got %b/%h want 1/00000700", mem_req, mem_addr); end
    tick(); // cycle 2
    n_cmp++; if ({if_ready, if_rdata} !== {1'b1, 32'h77777777}) begin n_err++; $display("FAIL rstmid_fetch_done: got %b/%h want 1/77777777", if_ready, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_read();
    test_back_to_back();
    test_starvation();
    test_flush();
    test_reset_midtx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
